// File: rtl/sd_seq_check_pkg.sv
// ----------------------------------------------------------------------------
// sd_chk_pkg
//   Shared definitions for the sd_seq_check sink-side checker:
//   - beat field positions as functions of the beat width
//     (dst in the top 2 bits, src in the next 2, seq in the rest)
//   - error code and drdy mode encodings
//   - counter width and saturation value
//   - step function for the 8-bit throttle LFSR (x^8+x^6+x^5+x^4+1)
// ----------------------------------------------------------------------------
package sd_chk_pkg;

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_DST  = 2'd1,
      ERR_SEQ  = 2'd2,
      ERR_BOTH = 2'd3
   } err_code_e;

   typedef enum int unsigned {
      DRDY_ALWAYS = 0,
      DRDY_LFSR   = 1,
      DRDY_STALL  = 2
   } drdy_mode_e;

   function automatic int unsigned DST_HI(input int unsigned w);
      return w - 1;
   endfunction

   function automatic int unsigned DST_LO(input int unsigned w);
      return w - 2;
   endfunction

   function automatic int unsigned SRC_HI(input int unsigned w);
      return w - 3;
   endfunction

   function automatic int unsigned SRC_LO(input int unsigned w);
      return w - 4;
   endfunction

   function automatic int unsigned SEQ_W(input int unsigned w);
      return w - 4;
   endfunction

   // Feedback bit; it is also bit 0 of the next state.
   function automatic logic lfsr8_fb(input logic [7:0] s);
      return s[7] ^ s[5] ^ s[4] ^ s[3];
   endfunction

   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6:0], lfsr8_fb(s)};
   endfunction

endpackage

// File: rtl/sd_seq_check_if.sv
// ----------------------------------------------------------------------------
// sd_seq_check_if
//   srdy/drdy beat handshake between an sd_mirror output port and its sink.
//   c_srdy  : beat valid       (master -> slave)
//   c_data  : beat, width bits (master -> slave)
//   c_drdy  : sink ready       (slave  -> master)
// ----------------------------------------------------------------------------
interface sd_seq_check_if #(
   parameter int unsigned width = 8
);
   logic             c_srdy;
   logic             c_drdy;
   logic [width-1:0] c_data;

   modport master (output c_srdy, output c_data, input c_drdy);
   modport slave  (input c_srdy, input c_data, output c_drdy);
endinterface

// File: rtl/sd_seq_check_lfsr8.sv
// ----------------------------------------------------------------------------
// sd_lfsr8
//   Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
//   clk   in  1  clock
//   reset in  1  synchronous active-low; loads seed
//   seed  in  8  reset value, must be nonzero
//   out   out 8  current state
// ----------------------------------------------------------------------------
module sd_lfsr8
   import sd_chk_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] out
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!reset) lfsr_q <= seed;
      else        lfsr_q <= lfsr8_next(lfsr_q);
   end

   assign out = lfsr_q;

endmodule

// File: rtl/sd_seq_check.sv
// ----------------------------------------------------------------------------
// sd_seq_check
//   Sink-side checker on one sd_mirror output port. Accepts beats on an
//   srdy/drdy handshake with a programmable drdy throttle, checks each beat's
//   dst field against this port's id and each source's sequence stream, and
//   keeps saturating receive/error counters plus a first-error record.
//   clk       in   1      clock
//   reset     in   1      synchronous, active-low
//   c         slave       c_srdy/c_data in, c_drdy out (flop driven)
//   rx_count  out  16     accepted beats, saturating
//   err_count out  16     beats with any error, saturating
//   err_flag  out  1      sticky error seen
//   err_code  out  2      first error: 1 dst, 2 seq, 3 both
//   err_data  out  width  beat that caused the first error
// ----------------------------------------------------------------------------
module sd_seq_check
   import sd_chk_pkg::*;
#(
   parameter int unsigned width     = 8,
   parameter int unsigned id        = 0,
   parameter int unsigned drdy_mode = 0,
   parameter int unsigned stall     = 2,
   parameter logic [7:0]  seed      = 8'hA5
) (
   input  logic             clk,
   input  logic             reset,
   sd_seq_check_if.slave    c,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic [1:0]       err_code,
   output logic [width-1:0] err_data
);

   localparam int unsigned SW  = SEQ_W(width);
   localparam int unsigned DH  = DST_HI(width);
   localparam int unsigned DL  = DST_LO(width);
   localparam int unsigned SH  = SRC_HI(width);
   localparam int unsigned SL  = SRC_LO(width);
   localparam logic [1:0]  ID2 = 2'(id);
   localparam logic [3:0]  STALL_V = 4'(stall);

   logic             xfer;
   logic [1:0]       dst, src;
   logic [SW-1:0]    seq;
   logic             dst_err, seq_err;

   logic [SW-1:0]    exp_q [4];
   logic [CNT_W-1:0] rx_q, rx_d, err_q, err_d;
   logic             flag_q, flag_d;
   err_code_e        code_q, code_d;
   logic [width-1:0] edata_q, edata_d;
   logic             drdy_q, drdy_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       lfsr;

   if (drdy_mode == DRDY_LFSR) begin : g_lfsr
      sd_lfsr8 u_lfsr (
         .clk   (clk),
         .reset (reset),
         .seed  (seed),
         .out   (lfsr)
      );
   end else begin : g_no_lfsr
      assign lfsr = '0;
   end

   assign xfer = c.c_srdy & drdy_q;
   assign dst  = c.c_data[DH:DL];
   assign src  = c.c_data[SH:SL];
   assign seq  = c.c_data[SW-1:0];

   always_comb begin
      dst_err = (dst != ID2);
      seq_err = (seq != exp_q[src]);
      rx_d    = rx_q;
      err_d   = err_q;
      flag_d  = flag_q;
      code_d  = code_q;
      edata_d = edata_q;
      if (xfer) begin
         if (rx_q != CNT_MAX) rx_d = rx_q + 1'b1;
         if (dst_err | seq_err) begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            flag_d = 1'b1;
            if (!flag_q) begin
               code_d  = err_code_e'({seq_err, dst_err});
               edata_d = c.c_data;
            end
         end
      end
   end

   // drdy is registered from the next throttle state, so it never depends on
   // c_srdy/c_data within the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (xfer)               cnt_d = STALL_V;
      else if (cnt_q != 4'd0) cnt_d = cnt_q - 1'b1;
      if (drdy_mode == DRDY_LFSR)       drdy_d = lfsr8_fb(lfsr);
      else if (drdy_mode == DRDY_STALL) drdy_d = (cnt_d == 4'd0);
      else                              drdy_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_q    <= '0;
         err_q   <= '0;
         flag_q  <= 1'b0;
         code_q  <= ERR_NONE;
         edata_q <= '0;
         drdy_q  <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < 4; i++) exp_q[i] <= '0;
      end else begin
         rx_q    <= rx_d;
         err_q   <= err_d;
         flag_q  <= flag_d;
         code_q  <= code_d;
         edata_q <= edata_d;
         drdy_q  <= drdy_d;
         cnt_q   <= cnt_d;
         // Always resync to the received value so a gap costs one error.
         if (xfer) exp_q[src] <= seq + 1'b1;
      end
   end

   assign c.c_drdy  = drdy_q;
   assign rx_count  = rx_q;
   assign err_count = err_q;
   assign err_flag  = flag_q;
   assign err_code  = code_q;
   assign err_data  = edata_q;

endmodule

// File: tb/tb_sd_seq_check.sv
// ----------------------------------------------------------------------------
// tb_sd_seq_check
//   Three checkers side by side: u0 mode 0 id 2 (directed beats), u1 mode 1
//   id 1 (random beats), u2 mode 2 id 0 stall 3 (c_srdy held high). A
//   behavioural model tracks all three and is compared every cycle; directed
//   literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_sd_seq_check;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          done = 1'b0;

   sd_seq_check_if #(.width(8)) if0 ();
   sd_seq_check_if #(.width(8)) if1 ();
   sd_seq_check_if #(.width(8)) if2 ();

   logic [15:0] rx_w    [3];
   logic [15:0] err_w   [3];
   logic        flag_w  [3];
   logic [1:0]  code_w  [3];
   logic [7:0]  edata_w [3];
   logic        drdy_w  [3];
   logic        srdy_w  [3];
   logic [7:0]  data_w  [3];

   assign drdy_w[0] = if0.c_drdy;
   assign drdy_w[1] = if1.c_drdy;
   assign drdy_w[2] = if2.c_drdy;
   assign srdy_w[0] = if0.c_srdy;
   assign srdy_w[1] = if1.c_srdy;
   assign srdy_w[2] = if2.c_srdy;
   assign data_w[0] = if0.c_data;
   assign data_w[1] = if1.c_data;
   assign data_w[2] = if2.c_data;

   sd_seq_check #(.width(8), .id(2), .drdy_mode(0), .stall(2), .seed(8'hA5)) u0 (
      .clk(clk), .reset(reset), .c(if0.slave),
      .rx_count(rx_w[0]), .err_count(err_w[0]), .err_flag(flag_w[0]),
      .err_code(code_w[0]), .err_data(edata_w[0]));

   sd_seq_check #(.width(8), .id(1), .drdy_mode(1), .stall(2), .seed(8'hA5)) u1 (
      .clk(clk), .reset(reset), .c(if1.slave),
      .rx_count(rx_w[1]), .err_count(err_w[1]), .err_flag(flag_w[1]),
      .err_code(code_w[1]), .err_data(edata_w[1]));

   sd_seq_check #(.width(8), .id(0), .drdy_mode(2), .stall(3), .seed(8'hA5)) u2 (
      .clk(clk), .reset(reset), .c(if2.slave),
      .rx_count(rx_w[2]), .err_count(err_w[2]), .err_flag(flag_w[2]),
      .err_code(code_w[2]), .err_data(edata_w[2]));

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[u%0d]: got 0x%0h, want 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_rx [3], m_err [3], m_code [3], m_edata [3];
   int m_exp [3][4];
   bit m_flag [3], m_drdy [3];
   int m_lfsr, m_since;
   bit m_valid = 1'b0;

   function automatic int id_of(input int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 0;
   endfunction

   task automatic beat(input int k, input int d);
      int dst, src, seq;
      bit derr, serr;
      dst  = (d >> 6) & 3;
      src  = (d >> 4) & 3;
      seq  = d & 15;
      derr = (dst != id_of(k));
      serr = (seq != m_exp[k][src]);
      m_exp[k][src] = (seq + 1) % 16;
      if (m_rx[k] < 65535) m_rx[k]++;
      if (derr || serr) begin
         if (m_err[k] < 65535) m_err[k]++;
         if (!m_flag[k]) begin
            m_code[k]  = 2 * int'(serr) + int'(derr);
            m_edata[k] = d;
         end
         m_flag[k] = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (reset === 1'b0) begin
         for (int k = 0; k < 3; k++) begin
            m_rx[k] = 0; m_err[k] = 0; m_code[k] = 0; m_edata[k] = 0;
            m_flag[k] = 1'b0; m_drdy[k] = 1'b0;
            for (int s = 0; s < 4; s++) m_exp[k][s] = 0;
         end
         m_lfsr  = 8'hA5;
         m_since = 3;
         m_valid = 1'b1;
      end else if (m_valid) begin
         bit x;
         for (int k = 0; k < 3; k++) begin
            x = srdy_w[k] && m_drdy[k];
            if (x) beat(k, int'(data_w[k]));
            if (k == 0) m_drdy[k] = 1'b1;
            else if (k == 1) begin
               m_lfsr = ((m_lfsr << 1) & 8'hFE) |
                        (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
               m_drdy[k] = m_lfsr[0];
            end else begin
               // Ready once `stall` full cycles have passed since the last accept.
               m_since = x ? 0 : ((m_since < 100) ? m_since + 1 : m_since);
               m_drdy[k] = (m_since >= 3);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         for (int k = 0; k < 3; k++) begin
            chk("c_drdy",    k, 32'(drdy_w[k]),  32'(m_drdy[k]));
            chk("rx_count",  k, 32'(rx_w[k]),    m_rx[k]);
            chk("err_count", k, 32'(err_w[k]),   m_err[k]);
            chk("err_flag",  k, 32'(flag_w[k]),  32'(m_flag[k]));
            chk("err_code",  k, 32'(code_w[k]),  m_code[k]);
            chk("err_data",  k, 32'(edata_w[k]), m_edata[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send0(input logic [7:0] d);
      int n;
      if0.c_srdy = 1'b1;
      if0.c_data = d;
      n = 0;
      while (!drdy_w[0] && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("u0_accept_wait", 0, 32'(n < 64), 1);
      @(negedge clk);
      if0.c_srdy = 1'b0;
   endtask

   task automatic do_reset();
      logic [7:0] p0, p1, p2;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rx_count",  0, 32'(rx_w[0]),    0);
      chk("rst_err_count", 0, 32'(err_w[0]),   0);
      chk("rst_err_flag",  0, 32'(flag_w[0]),  0);
      chk("rst_err_code",  0, 32'(code_w[0]),  0);
      chk("rst_err_data",  0, 32'(edata_w[0]), 0);
      chk("rst_drdy",      1, 32'(drdy_w[1]),  0);
      if0.c_srdy = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         p0[i] = drdy_w[0];
         p1[i] = drdy_w[1];
         p2[i] = drdy_w[2];
      end
      chk("drdy_pattern_mode0", 0, 32'(p0), 32'h0000_00FF);
      chk("drdy_pattern_lfsr",  1, 32'(p1), 32'h0000_0072);
      chk("drdy_pattern_stall", 2, 32'(p2), 32'h0000_0011);
      repeat (8) @(negedge clk);
      chk("stall_rx_16cyc", 2, 32'(rx_w[2]), 4);
   endtask

   initial begin
      reset      = 1'b0;
      if0.c_srdy = 1'b0;
      if0.c_data = '0;

      do_reset();
      send0(8'h90); send0(8'h91); send0(8'h92);
      chk("t1_rx",   0, 32'(rx_w[0]),   3);
      chk("t1_err",  0, 32'(err_w[0]),  0);
      chk("t1_flag", 0, 32'(flag_w[0]), 0);

      do_reset();
      send0(8'h80); send0(8'h83);
      chk("t2_err_after_gap", 0, 32'(err_w[0]), 1);
      send0(8'h84);
      chk("t2_err",  0, 32'(err_w[0]),   1);
      chk("t2_code", 0, 32'(code_w[0]),  2);
      chk("t2_data", 0, 32'(edata_w[0]), 32'h83);

      do_reset();
      send0(8'h40); send0(8'hC5);
      chk("t3_err",  0, 32'(err_w[0]),   2);
      chk("t3_code", 0, 32'(code_w[0]),  1);
      chk("t3_data", 0, 32'(edata_w[0]), 32'h40);
      chk("t3_flag", 0, 32'(flag_w[0]),  1);

      do_reset();
      for (int s = 0; s < 16; s++) send0(8'(32'hA0 | s));
      send0(8'hA0);
      chk("t4_rx",  0, 32'(rx_w[0]),  17);
      chk("t4_err", 0, 32'(err_w[0]), 0);

      for (int s = 0; s < 5; s++) send0(8'(32'hB0 | s));
      chk("t6_pre_err", 0, 32'(err_w[0]), 0);
      // Reset with a beat offered on the reset edge: it must be dropped.
      reset      = 1'b0;
      if0.c_srdy = 1'b1;
      if0.c_data = 8'hB5;
      do_reset();
      send0(8'hB0);
      chk("t6_rx",   0, 32'(rx_w[0]),   1);
      chk("t6_err",  0, 32'(err_w[0]),  0);
      chk("t6_flag", 0, 32'(flag_w[0]), 0);

      done = 1'b1;
      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // u1: random beats, mostly in order, occasional dst/seq faults and idles.
   initial begin
      int sq [4];
      int n, src, seq, dst;
      if1.c_srdy = 1'b0;
      if1.c_data = '0;
      for (int s = 0; s < 4; s++) sq[s] = 0;
      @(negedge clk);
      while (!done) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         src = int'($urandom_range(0, 3));
         dst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 1;
         seq = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : sq[src];
         if1.c_srdy = 1'b1;
         if1.c_data = 8'((dst << 6) | (src << 4) | seq);
         n = 0;
         while (!drdy_w[1] && n < 64) begin
            @(negedge clk);
            n++;
         end
         chk("u1_accept_wait", 1, 32'(n < 64), 1);
         @(negedge clk);
         if1.c_srdy = 1'b0;
         sq[src] = (seq + 1) % 16;
      end
   end

   // u2: c_srdy held high; new beat after each accept, occasional seq skip.
   initial begin
      int  seq;
      bit  last;
      seq  = 0;
      last = 1'b0;
      if2.c_srdy = 1'b1;
      if2.c_data = 8'h10;
      forever begin
         @(negedge clk);
         if (last) begin
            seq = ($urandom_range(0, 7) == 0) ? (seq + 2) % 16 : (seq + 1) % 16;
            if2.c_data = 8'(32'h10 | seq);
         end
         last = drdy_w[2];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
